// File: rtl/mawg_sample_out.sv
// Sample FIFO and rate-paced DAC replay stage behind mawg.
// Optional output scaling (gain/offset, one extra clock of latency) under `MAWG_SAMPLE_OUT_SCALE_EN.
module mawg_sample_out #(
    parameter int WAVE_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   src_busy,
    input  logic                   wave_valid,
    input  logic [WAVE_WIDTH-1:0]  wave_out,
    input  logic [DIV_WIDTH-1:0]   rate_div,
    input  logic [FIFO_DEPTH:0]    prime_level,
    input  logic                   clear_flags,
`ifdef MAWG_SAMPLE_OUT_SCALE_EN
    input  logic signed [15:0]     gain,
    input  logic signed [WAVE_WIDTH-1:0] offset,
`endif
    output logic [WAVE_WIDTH-1:0]  dac_data,
    output logic                   dac_strobe,
    output logic [FIFO_DEPTH:0]    fifo_level,
    output logic                   playing,
    output logic                   done,
    output logic                   overflow,
    output logic                   underrun,
    output logic [1:0]             state_dbg
);

    localparam int ENTRIES = 2 ** FIFO_DEPTH;
    localparam logic [FIFO_DEPTH:0]   FULL_LEVEL = (FIFO_DEPTH + 1)'(ENTRIES);
    localparam logic [FIFO_DEPTH:0]   LVL_ONE    = (FIFO_DEPTH + 1)'(1);
    localparam logic [FIFO_DEPTH-1:0] PTR_ONE    = FIFO_DEPTH'(1);
    localparam logic [DIV_WIDTH-1:0]  CNT_ONE    = DIV_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRIME = 2'd1, S_PLAY = 2'd2} state_t;

    state_t                 state;
    logic [WAVE_WIDTH-1:0]  mem [ENTRIES];
    logic [FIFO_DEPTH-1:0]  wr_ptr, rd_ptr;
    logic [DIV_WIDTH-1:0]   count, div_q;
    logic [WAVE_WIDTH-1:0]  sample_q;
    logic                   sample_stb;

    logic fifo_empty, fifo_full, tick, do_pop, push_req, do_push;
    logic ovf_event, urun_event, start_play;
    logic [FIFO_DEPTH:0] prime_eff;

    // wave_valid is a one-way strobe with no ready: a sample offered while the
    // FIFO is full (and nothing leaves that cycle) is dropped and flagged.
    always_comb begin
        fifo_empty = (fifo_level == '0);
        fifo_full  = (fifo_level == FULL_LEVEL);
        tick       = enable && (state == S_PLAY) && (count == div_q);
        do_pop     = tick && !fifo_empty;
        push_req   = enable && wave_valid && (state != S_IDLE);
        do_push    = push_req && (!fifo_full || do_pop);
        ovf_event  = push_req && fifo_full && !do_pop;
        urun_event = tick && fifo_empty && src_busy;
        prime_eff  = (prime_level == '0) ? LVL_ONE : prime_level;
        start_play = (fifo_level >= prime_eff) || (!fifo_empty && !src_busy);
    end

    assign playing   = (state == S_PLAY);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wave_out;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            count      <= '0;
            div_q      <= '0;
            sample_q   <= '0;
            sample_stb <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            sample_stb <= 1'b0;
            done       <= 1'b0;
            if (!enable) begin
                state      <= S_IDLE;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_level <= '0;
                count      <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
                if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
                case ({do_push, do_pop})
                    2'b10:   fifo_level <= fifo_level + LVL_ONE;
                    2'b01:   fifo_level <= fifo_level - LVL_ONE;
                    default: fifo_level <= fifo_level;
                endcase
                case (state)
                    S_IDLE: state <= S_PRIME;
                    S_PRIME: begin
                        if (start_play) begin
                            state <= S_PLAY;
                            count <= '0;
                            div_q <= rate_div;
                        end
                    end
                    S_PLAY: begin
                        // The period is latched at each wrap so rate_div edits never cut a period short.
                        if (tick) begin
                            count <= '0;
                            div_q <= rate_div;
                            if (!fifo_empty) begin
                                sample_q   <= mem[rd_ptr];
                                sample_stb <= 1'b1;
                            end else if (src_busy) begin
                                sample_stb <= 1'b1;
                            end else begin
                                state <= S_PRIME;
                                done  <= 1'b1;
                            end
                        end else begin
                            count <= count + CNT_ONE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
            if (ovf_event)        overflow <= 1'b1;
            else if (clear_flags) overflow <= 1'b0;
            if (urun_event)       underrun <= 1'b1;
            else if (clear_flags) underrun <= 1'b0;
        end
    end

`ifdef MAWG_SAMPLE_OUT_SCALE_EN
    localparam int PW = WAVE_WIDTH + 16;
    localparam logic signed [PW:0] SAT_MAX = {{(PW - WAVE_WIDTH + 2){1'b0}}, {(WAVE_WIDTH - 1){1'b1}}};
    localparam logic signed [PW:0] SAT_MIN = {{(PW - WAVE_WIDTH + 2){1'b1}}, {(WAVE_WIDTH - 1){1'b0}}};

    logic signed [PW-1:0] prod, prod_sh;
    logic signed [PW:0]   sum;

    // Q2.14 gain: full-width signed product, arithmetic shift back, then offset.
    always_comb begin
        prod    = $signed({{16{sample_q[WAVE_WIDTH-1]}}, sample_q})
                * $signed({{WAVE_WIDTH{gain[15]}}, gain});
        prod_sh = prod >>> 14;
        sum     = $signed({prod_sh[PW-1], prod_sh})
                + $signed({{(PW + 1 - WAVE_WIDTH){offset[WAVE_WIDTH-1]}}, offset});
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dac_data   <= '0;
            dac_strobe <= 1'b0;
        end else begin
            dac_strobe <= sample_stb;
            if (sample_stb) begin
                if (sum > SAT_MAX)      dac_data <= SAT_MAX[WAVE_WIDTH-1:0];
                else if (sum < SAT_MIN) dac_data <= SAT_MIN[WAVE_WIDTH-1:0];
                else                    dac_data <= sum[WAVE_WIDTH-1:0];
            end
        end
    end
`else
    assign dac_data   = sample_q;
    assign dac_strobe = sample_stb;
`endif

endmodule
